// File: rtl/ack_pkg.sv
// ack_pkg: definitions shared by the ack bus arbiter and the ack event queue.
//   SRC_*   : source-id encodings carried on the ack bus
//   NUM_SRC : number of distinct ack sources
//   ack_id_t: 2-bit source-id type
package ack_pkg;

   typedef logic [1:0] ack_id_t;

   localparam int NUM_SRC = 4;

   localparam ack_id_t SRC_MEM  = 2'd0;
   localparam ack_id_t SRC_SHA  = 2'd1;
   localparam ack_id_t SRC_AES  = 2'd2;
   localparam ack_id_t SRC_CTRL = 2'd3;

endpackage

// File: rtl/ack_fifo.sv
// ack_fifo: generic synchronous FIFO with first-word fall-through output.
//   clk, rst         : clock and synchronous active-high reset
//   push, push_data  : write request and data
//   pop              : read request (ignored while empty)
//   pop_data         : head entry, forced to 0 while empty
//   full, empty      : occupancy flags
//   level            : current occupancy, 0..DEPTH
//   push_ok, pop_ok  : the write / read actually taken this cycle
// A push while full is still taken if a pop is taken in the same cycle.
module ack_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     push_ok,
   output logic                     pop_ok
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [LW-1:0]    level_reg;

   assign full    = (level_reg == LW'(DEPTH));
   assign empty   = (level_reg == '0);
   assign pop_ok  = pop && !empty;
   // pop-through: the slot freed by this cycle's read takes the new write
   assign push_ok = push && (!full || pop_ok);

   assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];
   assign level    = level_reg;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   level_reg <= level_reg + LW'(1);
            2'b01:   level_reg <= level_reg - LW'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/ack_event_queue.sv
// ack_event_queue: captures ack bus transfers into a FIFO and presents them
// to the control sequencer over valid/ready.
//   clk, rst       : clock and synchronous active-high reset
//   ack_valid_n    : ack bus valid (active-low), one transfer per low cycle
//   ack_id         : source id of the transfer
//   evt_valid      : head event available
//   evt_id         : head event source id, 0 when empty
//   evt_ready      : consumer takes the head this cycle
//   pending_mask   : bit i set while source i has an event queued
//   level          : FIFO occupancy
//   overflow       : sticky flag, a transfer was dropped
//   drop_cnt       : saturating count of dropped transfers
//   clr_ovf        : clears overflow and drop_cnt (a same-cycle drop wins)
module ack_event_queue
   import ack_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ack_valid_n,
   input  logic [1:0]              ack_id,
   output logic                    evt_valid,
   output logic [1:0]              evt_id,
   input  logic                    evt_ready,
   output logic [3:0]              pending_mask,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow,
   output logic [7:0]              drop_cnt,
   input  logic                    clr_ovf
);

   logic    push;
   logic    push_ok;
   logic    pop_ok;
   logic    full;
   logic    empty;
   logic    drop;
   ack_id_t head_id;

   logic [CNT_W-1:0]   cnt_reg  [NUM_SRC];
   logic [CNT_W-1:0]   cnt_next [NUM_SRC];
   logic [NUM_SRC-1:0] pending_mask_reg;
   logic               overflow_reg;
   logic [7:0]         drop_cnt_reg;

   assign push = !ack_valid_n;
   assign drop = push && !push_ok;

   ack_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (ack_id),
      .pop       (evt_ready),
      .pop_data  (head_id),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .push_ok   (push_ok),
      .pop_ok    (pop_ok)
   );

   // evt_valid comes from registered occupancy only, never from evt_ready.
   assign evt_valid = !empty;
   assign evt_id    = head_id;

   // Per-source outstanding counts. A simultaneous +1/-1 on the same source
   // cancels; the count is bounded by DEPTH so it cannot wrap.
   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         logic inc;
         logic dec;
         assign inc = push_ok && (ack_id == ack_id_t'(gi));
         assign dec = pop_ok && (head_id == ack_id_t'(gi));
         always_comb begin
            cnt_next[gi] = cnt_reg[gi];
            if (inc && !dec) begin
               cnt_next[gi] = cnt_reg[gi] + CNT_W'(1);
            end else if (dec && !inc) begin
               cnt_next[gi] = cnt_reg[gi] - CNT_W'(1);
            end
         end
      end
   endgenerate

   // The mask is registered from the next-state counts so it moves on the
   // same edge as the counters and the FIFO level.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            cnt_reg[i] <= '0;
         end
         pending_mask_reg <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            cnt_reg[i]          <= cnt_next[i];
            pending_mask_reg[i] <= (cnt_next[i] != '0);
         end
      end
   end

   // Drop diagnostics; a drop in the clear cycle counts as the first drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
      end else if (drop) begin
         overflow_reg <= 1'b1;
         if (clr_ovf) begin
            drop_cnt_reg <= 8'd1;
         end else if (drop_cnt_reg != 8'hFF) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
         end
      end else if (clr_ovf) begin
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
      end
   end

   assign pending_mask = pending_mask_reg;
   assign overflow     = overflow_reg;
   assign drop_cnt     = drop_cnt_reg;

   // full is implied by push_ok; referenced here to document the drop cause.
   logic unused_full;
   assign unused_full = full;

endmodule
